sequence_detector_moore_verilog: RTL and testbench



---
 rtl/sequence_detector_moore_verilog_pkg.sv | 7 +
 rtl/sequence_detector_moore_verilog.sv | 50 +++++
 tb/tb_sequence_detector_moore_verilog.sv | 113 +++++++++++
 3 files changed

// File: rtl/sequence_detector_moore_verilog_pkg.sv
// Shared constants for the serial 1011 Moore detector.
// The state encoding itself stays private to the detector.
package sequence_detector_moore_verilog_pkg;

    localparam int STATE_W = 3;

endpackage

// File: rtl/sequence_detector_moore_verilog.sv
// Moore FSM spotting the overlapping serial pattern 1011.
// detector_out is decoded from the state register only.
module sequence_detector_moore_verilog
    import sequence_detector_moore_verilog_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic sequence_in,
    output logic detector_out
);

    localparam logic [STATE_W-1:0] S_ZERO         = 3'd0;
    localparam logic [STATE_W-1:0] S_ONE          = 3'd1;
    localparam logic [STATE_W-1:0] S_ONE_ZERO     = 3'd2;
    localparam logic [STATE_W-1:0] S_ONE_ZERO_ONE = 3'd3;
    localparam logic [STATE_W-1:0] S_DETECT       = 3'd4;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_ZERO;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_ZERO;
        unique case (state)
            S_ZERO:
                state_nxt = sequence_in ? S_ONE : S_ZERO;
            S_ONE:
                state_nxt = sequence_in ? S_ONE : S_ONE_ZERO;
            S_ONE_ZERO:
                state_nxt = sequence_in ? S_ONE_ZERO_ONE : S_ZERO;
            S_ONE_ZERO_ONE:
                state_nxt = sequence_in ? S_DETECT : S_ONE_ZERO;
            // trailing 1 of a hit seeds the next match
            S_DETECT:
                state_nxt = sequence_in ? S_ONE : S_ONE_ZERO;
            default:
                state_nxt = S_ZERO;
        endcase
    end

    assign detector_out = (state == S_DETECT);

endmodule

// File: tb/tb_sequence_detector_moore_verilog.sv
// Directed bench for the 1011 Moore detector.
// Inputs change on the falling edge; outputs sampled 1 ns after rising.
module tb_sequence_detector_moore_verilog;

    logic clock;
    logic reset;
    logic sequence_in;
    logic detector_out;

    int n_checks = 0;
    int n_errors = 0;

    sequence_detector_moore_verilog dut (
        .clock        (clock),
        .reset        (reset),
        .sequence_in  (sequence_in),
        .detector_out (detector_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic b, input logic exp, input string tag);
        @(negedge clock);
        sequence_in = b;
        @(posedge clock);
        #1;
        chk(tag, detector_out, exp);
    endtask

    task automatic run(
        input string tag,
        input int    len,
        input logic [15:0] bits,
        input logic [15:0] exps
    );
        for (int i = 0; i < len; i++) begin
            drive(bits[len-1-i], exps[len-1-i],
                  $sformatf("%s[%0d]", tag, i + 1));
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_async", detector_out, 1'b0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        sequence_in = 1'b1;
        #1;
        chk("rst_init", detector_out, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            chk($sformatf("rst_hold%0d", i), detector_out, 1'b0);
        end
        @(negedge clock);
        reset = 1'b1;

        run("basic", 4, 16'b1011, 16'b0001);
        // from S_ONE_ZERO a 1,1 must complete a hit
        run("basic_tail", 3, 16'b011, 16'b001);

        do_reset();
        run("overlap", 7, 16'b1011011, 16'b0001001);

        do_reset();
        run("nofalse", 16, 16'b0011001111111100, 16'h0000);

        do_reset();
        run("partial", 6, 16'b101011, 16'b000001);

        // async clear mid-cycle while detect is high
        do_reset();
        run("pre_async", 4, 16'b1011, 16'b0001);
        #2;
        reset = 1'b0;
        #1;
        chk("async_clr", detector_out, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        run("mid_pre", 3, 16'b101, 16'b000);
        do_reset();
        run("mid_post1", 1, 16'b1, 16'b0);
        run("mid_post2", 3, 16'b011, 16'b001);
        run("mid_post3", 4, 16'b1011, 16'b0001);
        run("mid_lone", 3, 16'b011, 16'b001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
